// File: rtl/cntr_pkg.sv
// Shared definitions for the loadable wrap counter and its load sequencer.
package cntr_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WRAP,
    LOAD,
    GAP
  } state_e;

  function automatic int unsigned cnt_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/cntr_load_fifo.sv
// Small synchronous FIFO buffering counter reload values; flush overrides push/pop.
module cntr_load_fifo
  import cntr_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign do_push = push && !flush && (level_q != LW'(DEPTH));
  assign do_pop  = pop && !flush && (level_q != '0);
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/cntr_load_sequencer.sv
// Feeds buffered reload values to the wrap counter as single-cycle load pulses,
// optionally aligned so the load lands on the counter's wrap cycle.
module cntr_load_sequencer
  import cntr_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MIN_GAP = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   sync_mode,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_val,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       cnt_in,
  output logic                   ld_in,
  output logic [WIDTH-1:0]       ld_val,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy
);

  localparam int unsigned     LW         = $clog2(DEPTH) + 1;
  localparam int unsigned     GW         = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX    = WIDTH'(cnt_max(WIDTH));
  localparam logic [WIDTH-1:0] CNT_MAX_M1 = WIDTH'(cnt_max(WIDTH) - 1);
  localparam logic [GW-1:0]    GAP_LAST   = GW'(MIN_GAP - 1);

  state_e           state_q, state_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] prev_cnt_q, prev_cnt_d;
  logic             ld_in_q, ld_in_d;
  logic [WIDTH-1:0] ld_val_q, ld_val_d;
  logic [WIDTH-1:0] fifo_head;
  logic             push, pop;

  assign in_ready = (fifo_level != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == LOAD);
  assign busy     = (state_q != IDLE) || (fifo_level != '0);
  assign ld_in    = ld_in_q;
  assign ld_val   = ld_val_q;

  cntr_load_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (in_val),
    .head  (fifo_head),
    .level (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    prev_cnt_d = cnt_in;
    ld_in_d    = 1'b0;
    ld_val_d   = ld_val_q;

    case (state_q)
      IDLE: begin
        if (fifo_level != '0) begin
          state_d = sync_mode ? WAIT_WRAP : LOAD;
        end
      end
      // Issuing at MAX-1 puts the pulse on the MAX cycle; a counter parked at MAX
      // never shows MAX-1, so two consecutive MAX samples also release the load.
      WAIT_WRAP: begin
        if ((cnt_in == CNT_MAX_M1) ||
            ((cnt_in == CNT_MAX) && (prev_cnt_q == CNT_MAX))) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d   = GAP;
        gap_cnt_d = '0;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d    = IDLE;
      prev_cnt_d = '0;
    end

    // The pulse is registered on entry to LOAD so it is visible during the LOAD cycle.
    if (state_d == LOAD) begin
      ld_in_d  = 1'b1;
      ld_val_d = fifo_head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      prev_cnt_q <= '0;
      ld_in_q    <= 1'b0;
      ld_val_q   <= '0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      prev_cnt_q <= prev_cnt_d;
      ld_in_q    <= ld_in_d;
      ld_val_q   <= ld_val_d;
    end
  end

endmodule

// File: tb/tb_cntr_load_sequencer.sv
// Self-checking bench: directed scenarios plus a randomized free-running phase
// compared against a queue-and-spacing model of the load sequencer.
module tb_cntr_load_sequencer;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MIN_GAP = 2;
  localparam int unsigned LW      = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             sync_mode;
  logic             in_valid;
  logic [WIDTH-1:0] in_val;
  logic             in_ready;
  logic [WIDTH-1:0] cnt_in;
  logic             ld_in;
  logic [WIDTH-1:0] ld_val;
  logic [LW-1:0]    fifo_level;
  logic             busy;

  int errors = 0;
  int checks = 0;
  logic run;
  logic [WIDTH-1:0] emitted [$];

  always #5 clk = ~clk;

  cntr_load_sequencer #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .MIN_GAP (MIN_GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .sync_mode  (sync_mode),
    .in_valid   (in_valid),
    .in_val     (in_val),
    .in_ready   (in_ready),
    .cnt_in     (cnt_in),
    .ld_in      (ld_in),
    .ld_val     (ld_val),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the bench-side wrap counter reacts to the pulse seen before the edge.
  task automatic tick();
    logic             pre_ld;
    logic [WIDTH-1:0] pre_val;
    pre_ld  = ld_in;
    pre_val = ld_val;
    @(posedge clk);
    #1;
    if (pre_ld === 1'b1) cnt_in = pre_val;
    else if (run) cnt_in = cnt_in + 4'd1;
    if (ld_in === 1'b1) emitted.push_back(ld_val);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic wait_pulse(input int bound, output int found, output int delay);
    found = 0;
    delay = 0;
    while (!found && delay < bound) begin
      tick();
      delay++;
      if (ld_in === 1'b1) found = 1;
    end
  endtask

  initial begin
    logic [WIDTH-1:0] vals [5];
    int found, delay;
    logic [WIDTH-1:0] mq [$];
    int last_pulse, t, pre_size;
    logic cur_ld, nxt_ld, do_push, do_pop;
    logic [WIDTH-1:0] exp_val;

    rst = 1'b1; flush = 1'b0; sync_mode = 1'b0; in_valid = 1'b0; in_val = '0;
    cnt_in = '0; run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ld_in", ld_in, 0);
    check("rst_ld_val", ld_val, 0);
    check("rst_level", fifo_level, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Single immediate load
    in_valid = 1'b1; in_val = 4'h9;
    tick();
    in_valid = 1'b0;
    check("t1_level", fifo_level, 1);
    check("t1_no_early_ld", ld_in, 0);
    tick();
    check("t1_ld_in", ld_in, 1);
    check("t1_ld_val", ld_val, 4'h9);
    tick();
    check("t1_ld_fall", ld_in, 0);
    check("t1_busy_gap1", busy, 1);
    tick();
    check("t1_busy_gap2", busy, 1);
    tick();
    check("t1_busy_done", busy, 0);
    check("t1_level_done", fifo_level, 0);

    // Fill FIFO while waiting for a wrap that does not come
    vals[0] = 4'h1; vals[1] = 4'h2; vals[2] = 4'h3; vals[3] = 4'h4; vals[4] = 4'h5;
    sync_mode = 1'b1; run = 1'b0; cnt_in = 4'h5;
    emitted.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_val = vals[i];
      tick();
    end
    check("t2_full_level", fifo_level, 4);
    check("t2_full_ready", in_ready, 0);
    in_val = vals[4];
    tick();
    tick();
    check("t2_hold_level", fifo_level, 4);
    cnt_in = 4'hE; run = 1'b1;
    tick();
    check("t2_sync_ld", ld_in, 1);
    check("t2_sync_cnt", cnt_in, 4'hF);
    check("t2_ready_during_ld", in_ready, 0);
    tick();
    check("t2_after_pop_level", fifo_level, 3);
    check("t2_after_pop_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t2_fifth_accepted", fifo_level, 4);
    sync_mode = 1'b0;
    for (int n = 0; n < 60 && emitted.size() < 5; n++) tick();
    check("t2_emit_count", emitted.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < emitted.size()) check("t2_order", emitted[i], vals[i]);
    end
    wait_idle("t2_idle");

    // Sync mode with counter running from 3
    sync_mode = 1'b1; cnt_in = 4'h3; run = 1'b1;
    in_valid = 1'b1; in_val = 4'hA;
    tick();
    in_valid = 1'b0;
    wait_pulse(40, found, delay);
    check("t3_pulse_seen", found, 1);
    check("t3_pulse_on_max", cnt_in, 4'hF);
    check("t3_ld_val", ld_val, 4'hA);
    tick();
    check("t3_cnt_reloaded", cnt_in, 4'hA);
    wait_idle("t3_idle");

    // Counter parked at max
    run = 1'b0; cnt_in = 4'hF;
    repeat (3) tick();
    in_valid = 1'b1; in_val = 4'h2;
    tick();
    in_valid = 1'b0;
    wait_pulse(10, found, delay);
    check("t4_pulse_seen", found, 1);
    check("t4_pulse_delay", delay, 2);
    check("t4_ld_val", ld_val, 4'h2);
    tick();
    check("t4_cnt_reloaded", cnt_in, 4'h2);
    wait_idle("t4_idle");

    // Flush with a concurrent push
    sync_mode = 1'b1; run = 1'b0; cnt_in = 4'h5;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_val = 4'(4'hB + i);
      tick();
    end
    in_valid = 1'b0;
    check("t5_level3", fifo_level, 3);
    in_valid = 1'b1; in_val = 4'h7; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("t5_flush_level", fifo_level, 0);
    check("t5_flush_busy", busy, 0);
    check("t5_flush_ready", in_ready, 1);
    emitted.delete();
    run = 1'b1;
    repeat (20) tick();
    check("t5_no_ld", emitted.size(), 0);
    check("t5_value_dropped", fifo_level, 0);

    // Asynchronous reset during a load pulse
    sync_mode = 1'b0;
    in_valid = 1'b1; in_val = 4'h6;
    tick();
    in_valid = 1'b0;
    wait_pulse(5, found, delay);
    check("t6_pulse_seen", found, 1);
    rst = 1'b1;
    #1;
    check("t6_ld_in", ld_in, 0);
    check("t6_ld_val", ld_val, 0);
    check("t6_level", fifo_level, 0);
    check("t6_ready", in_ready, 1);
    check("t6_busy", busy, 0);
    tick();
    tick();
    rst = 1'b0;

    // Randomized traffic: loads follow accepted order with fixed spacing
    sync_mode = 1'b0; run = 1'b1;
    last_pulse = -100; t = 0; cur_ld = 1'b0;
    for (int n = 0; n < 400; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_val   = 4'($urandom);
      pre_size = mq.size();
      check("rnd_ready", in_ready, (pre_size < DEPTH) ? 1 : 0);
      do_push = in_valid && (pre_size < DEPTH);
      do_pop  = cur_ld;
      nxt_ld  = (pre_size > 0) && ((t - last_pulse) >= MIN_GAP + 1);
      exp_val = nxt_ld ? mq[0] : '0;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(in_val);
      tick();
      t++;
      if (nxt_ld) last_pulse = t;
      cur_ld = nxt_ld;
      check("rnd_ld_in", ld_in, nxt_ld);
      if (nxt_ld) check("rnd_ld_val", ld_val, exp_val);
      check("rnd_level", fifo_level, mq.size());
      check("rnd_busy", busy, ((mq.size() > 0) || ((t - last_pulse) <= MIN_GAP)) ? 1 : 0);
    end
    in_valid = 1'b0;
    wait_idle("rnd_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule

// File: doc/cntr_load_sequencer.md
# cntr_load_sequencer

Upstream feeder for the 4-bit loadable wrap counter. It accepts reload values over a valid/ready handshake, buffers them in a small FIFO and drives the counter's `ld_in`/`ld_val` pair one value at a time. In sync mode each load is timed to land exactly on the counter's wrap cycle. It watches the counter's `count_out` (fed back as `cnt_in`) to find that boundary.

## Interface
- `WIDTH`, default 4: counter and value width; `CNT_MAX` = 2^WIDTH-1.
- `DEPTH`, default 4: FIFO entries, power of two, ≥2.
- `MIN_GAP`, default 2: minimum idle cycles after a load pulse before the next load, ≥1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset `rst`, asynchronous, active-high.
- `flush` in 1: synchronous clear of FIFO and pending load.
- `sync_mode` in 1: 1 = load only at wrap boundary; 0 = load as soon as allowed. Sampled in IDLE only.
- `in_valid` in 1: reload value offered.
- `in_val` in WIDTH: reload value.
- `in_ready` out 1: FIFO not full; combinational from the level register.
- `cnt_in` in WIDTH: counter `count_out` feedback.
- `ld_in` out 1: registered one-cycle load pulse to the counter.
- `ld_val` out WIDTH: registered value, valid while `ld_in`=1, held afterwards.
- `fifo_level` out clog2(DEPTH)+1: entries stored.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.

## Operation
- Push occurs when `in_valid` && `in_ready`. There is no push-through when full; the upstream holds `in_val` until accepted.
- FSM states:
  - IDLE: FIFO non-empty → LOAD if `sync_mode`=0, else WAIT_WRAP.
  - WAIT_WRAP: → LOAD when `cnt_in`==CNT_MAX-1. Also → LOAD when `cnt_in`==CNT_MAX and `cnt_in` was CNT_MAX the previous cycle (counter stuck at max after a reload of CNT_MAX).
  - LOAD: one cycle. Registers `ld_in`=1 and `ld_val`=FIFO head, pops the FIFO, then → GAP.
  - GAP: counts MIN_GAP cycles with `ld_in`=0, then → IDLE.
- A load issued from WAIT_WRAP on `cnt_in`=CNT_MAX-1 is sampled by the counter in the cycle where it shows CNT_MAX. Load priority then replaces the wrap.
- `flush` clears the FIFO and returns the FSM to IDLE on the next edge. An `ld_in` pulse already registered still completes its single cycle.
- Flush concurrent with a push: flush wins and the value is dropped.
- Push concurrent with the LOAD pop: level is unchanged, and the push is allowed even when level=DEPTH-1.
- A previous-`cnt_in` register tracks stuck-at-max detection. It is cleared on reset and flush.

## Timing
- Reset values:
  - `ld_in`=0, `ld_val`=0, `fifo_level`=0, `in_ready`=1, `busy`=0.
  - State = IDLE, FIFO pointers = 0.
- Latency with `sync_mode`=0 and an empty idle block: push accepted at edge N, `ld_in` high during cycle N+1→N+2 (the cycle after the FSM leaves IDLE).
- Back-to-back loads are separated by exactly MIN_GAP+1 cycles of `ld_in`=0 when `sync_mode`=0 and the FIFO stays non-empty.
- In sync mode, `ld_in` is high in the same cycle that `cnt_in`==CNT_MAX.
- `in_ready` drops in the cycle after the DEPTH-th push and rises the cycle after a pop.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. The level counter saturates by construction.
- Reset mid-pulse forces `ld_in` to 0 immediately (asynchronous).

## Structure
- Shared package `cntr_pkg` holds:
  - state enum {IDLE, WAIT_WRAP, LOAD, GAP};
  - the CNT_MAX function of WIDTH;
  - the default WIDTH.
- One sub-module, `cntr_load_fifo`: a synchronous FIFO with push/pop/flush, head data and level output. The FSM and output registers stay in the top module.

## Test plan
- Reset, then `sync_mode`=0, push 4'h9 → `ld_in` pulses once with `ld_val`=9 two cycles later; `busy` returns to 0 after MIN_GAP+1 cycles.
- Push 5 values with DEPTH=4 and the FSM held in WAIT_WRAP → `in_ready`=0 after the 4th push; the 5th is accepted only after the first pop; all emerge in order.
- `sync_mode`=1, counter running from 4'h3, push 4'hA → `ld_in` high exactly in the cycle `cnt_in`=F; the counter next shows A, not 3.
- Counter reloaded with 4'hF (stuck), `sync_mode`=1, push 4'h2 → load is issued after 2 consecutive F samples; the counter next shows 2.
- FIFO holding 3 entries, assert `flush` together with `in_valid` → `fifo_level`=0, no further `ld_in`, and the concurrent value is dropped.
- Assert `rst` in the same cycle `ld_in`=1 → `ld_in` falls immediately; all outputs are at reset values.
